organ_key_scan: RTL

Front-end stage of the electronic organ: synchronises and debounces the 14 raw mechanical note buttons and produces the clean one-hot `Key[13:0]` vector consumed by the tone/display player (`yxt_2497_3`). It also gives a binary note code and a single-cycle press strobe for the auto/record logic. Clocked from the same 1 MHz `clk_in` as the player.

---
 rtl/organ_pkg.sv | 29 ++
 rtl/organ_key_scan_if.sv | 22 ++
 rtl/organ_key_sync.sv | 26 ++
 rtl/organ_key_scan.sv | 115 +++++++++++
 4 files changed

// File: rtl/organ_pkg.sv
// Shared types and helpers for the organ key scanner: key vector/code types,
// the debounce FSM state enum and the lowest-note priority helpers.
package organ_pkg;

  localparam int NUM_KEYS = 14;

  typedef logic [NUM_KEYS-1:0] key_vec_t;
  typedef logic [3:0]          key_code_t;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } scan_state_t;

  // Isolates the lowest set bit (two's-complement trick).
  function automatic key_vec_t lowest_onehot(input key_vec_t v);
    return v & (~v + key_vec_t'(1));
  endfunction

  function automatic key_code_t onehot_to_code(input key_vec_t oh);
    key_code_t c;
    c = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (oh[i]) c = key_code_t'(i + 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/organ_key_scan_if.sv
// Key scanner bus: raw button levels in, debounced note vector/code/strobe out.
// Outputs change only on a clock edge; key_press is a one-cycle pulse, no handshake.
interface organ_key_scan_if;
  import organ_pkg::*;

  key_vec_t    raw_key;
  key_vec_t    Key;
  key_code_t   key_code;
  logic        key_press;
  scan_state_t dbg_state;

  modport master (
    input  raw_key,
    output Key, key_code, key_press, dbg_state
  );

  modport slave (
    output raw_key,
    input  Key, key_code, key_press, dbg_state
  );

endinterface

// File: rtl/organ_key_sync.sv
// Two-flop synchroniser for the raw note button levels, async active-low reset.
module organ_key_sync
  import organ_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  key_vec_t d_i,
  output key_vec_t q_o
);

  key_vec_t s1_q;
  key_vec_t s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/organ_key_scan.sv
// Organ key front-end: synchronise, debounce the whole vector, pick the lowest note.
// Build option ORGAN_KEY_LATCH_EN: sustain mode, a release keeps the last note held.
module organ_key_scan
  import organ_pkg::*;
#(
  parameter int DB_CYCLES = 10000
) (
  input  logic              clk_in,
  input  logic              rst,
  organ_key_scan_if.master  bus
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  key_vec_t    s2;
  key_vec_t    stable_q, stable_d;
  key_vec_t    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  scan_state_t state_q, state_d;
  key_vec_t    key_q, key_d;
  key_code_t   code_q, code_d;
  logic        press_q, press_d;
  logic        commit;
  key_vec_t    new_key;
  key_code_t   new_code;

  organ_key_sync u_sync (
    .clk_i  (clk_in),
    .rst_ni (rst),
    .d_i    (bus.raw_key),
    .q_o    (s2)
  );

  assign new_key  = lowest_onehot(cand_q);
  assign new_code = onehot_to_code(new_key);

  always_comb begin
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2 != stable_q) begin
          cand_d  = s2;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (s2 == stable_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s2 != cand_q) begin
          cand_d = s2;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          stable_d = cand_q;
          state_d  = IDLE;
          commit   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers move only on a commit; the strobe fires on a new non-zero code.
  always_comb begin
    key_d   = key_q;
    code_d  = code_q;
    press_d = 1'b0;
    if (commit) begin
      press_d = (new_code != '0) && (new_code != code_q);
`ifdef ORGAN_KEY_LATCH_EN
      if (new_code != '0) begin
        key_d  = new_key;
        code_d = new_code;
      end
`else
      key_d  = new_key;
      code_d = new_code;
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      key_q    <= '0;
      code_q   <= '0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      key_q    <= key_d;
      code_q   <= code_d;
      press_q  <= press_d;
    end
  end

  assign bus.Key       = key_q;
  assign bus.key_code  = code_q;
  assign bus.key_press = press_q;
  assign bus.dbg_state = state_q;

endmodule
